// File: rtl/fwb_pkg.sv
// Shared definitions for the Wishbone slave-port protocol checker:
// violation bit positions and run-counter sizing.
package fwb_pkg;

  localparam int unsigned NUM_VIOL           = 8;

  localparam int unsigned VIOL_STB_NO_CYC    = 0;
  localparam int unsigned VIOL_STALL_CHANGE  = 1;
  localparam int unsigned VIOL_OVERFLOW      = 2;
  localparam int unsigned VIOL_CYC_AFTER_ERR = 3;
  localparam int unsigned VIOL_ACK_AND_ERR   = 4;
  localparam int unsigned VIOL_ACK_NONE      = 5;
  localparam int unsigned VIOL_STALL_TIMEOUT = 6;
  localparam int unsigned VIOL_ACK_TIMEOUT   = 7;

  // Bits needed to hold 0..limit; a disabled (0) limit still gets one bit.
  function automatic int unsigned run_width(input int unsigned limit);
    return (limit < 2) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/fwb_run_counter.sv
// Saturating run-length counter: counts consecutive cycles with en high, clears when en is low,
// and flags when the run passes (Inclusive=0) or reaches (Inclusive=1) Limit.
module fwb_run_counter
  import fwb_pkg::*;
#(
  parameter int unsigned Limit     = 1,
  parameter bit          Inclusive = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic hit
);

  localparam int unsigned Width = run_width(Limit);
  localparam logic [Width-1:0] LimitW  = Width'(Limit);
  localparam logic [Width-1:0] LimitM1 = (Limit == 0) ? '0 : Width'(Limit - 1);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!en) begin
      cnt_d = '0;
    end else if (cnt_q != LimitW) begin
      cnt_d = cnt_q + Width'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A zero limit disables the check entirely.
  always_comb begin
    hit = 1'b0;
    if (Limit != 0 && en) begin
      if (Inclusive) begin
        hit = (cnt_q >= LimitM1);
      end else begin
        hit = (cnt_q == LimitW);
      end
    end
  end

endmodule

// File: rtl/fwb_slave_checker.sv
// Passive Wishbone B4 pipelined slave-port checker: tracks request/ack counts and latches
// master- and slave-side rule violations as sticky bits.
module fwb_slave_checker
  import fwb_pkg::*;
#(
  parameter int unsigned AW              = 28,
  parameter int unsigned DW              = 32,
  parameter int unsigned F_MAX_STALL     = 0,
  parameter int unsigned F_MAX_ACK_DELAY = 0,
  parameter int unsigned F_LGDEPTH       = 4
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic                 i_wb_cyc,
  input  logic                 i_wb_stb,
  input  logic                 i_wb_we,
  input  logic [AW-1:0]        i_wb_addr,
  input  logic [DW-1:0]        i_wb_data,
  input  logic [DW/8-1:0]      i_wb_sel,
  input  logic                 i_wb_ack,
  input  logic                 i_wb_stall,
  input  logic [DW-1:0]        i_wb_idata,
  input  logic                 i_wb_err,
  output logic [F_LGDEPTH-1:0] f_nreqs,
  output logic [F_LGDEPTH-1:0] f_nacks,
  output logic [F_LGDEPTH-1:0] f_outstanding,
  output logic [NUM_VIOL-1:0]  o_viol,
  output logic                 o_master_err,
  output logic                 o_slave_err
);

  localparam int unsigned SW = DW / 8;

  logic req, resp, clr, stall_cond, wait_cond;
  logic stall_hit, ack_hit;

  logic [F_LGDEPTH-1:0] nreqs_q, nreqs_d, nacks_q, nacks_d;
  logic [NUM_VIOL-1:0]  viol_q, viol_d, viol_now;

  logic          past_valid_q, past_stall_q, past_we_q, past_err_q;
  logic [AW-1:0] past_addr_q;
  logic [DW-1:0] past_data_q;
  logic [SW-1:0] past_sel_q;

  // Read data carries no rule; it is only observed.
  logic unused_idata;
  assign unused_idata = ^i_wb_idata;

  assign req        = i_wb_cyc & i_wb_stb & ~i_wb_stall;
  assign resp       = i_wb_cyc & (i_wb_ack | i_wb_err);
  assign clr        = ~i_wb_cyc | i_wb_err;
  assign stall_cond = i_wb_cyc & i_wb_stb & i_wb_stall;
  assign wait_cond  = i_wb_cyc & (f_outstanding != '0) & ~i_wb_ack & ~i_wb_err;

  always_comb begin
    nreqs_d = nreqs_q + F_LGDEPTH'(req);
    nacks_d = nacks_q + F_LGDEPTH'(resp);
    if (clr) begin
      nreqs_d = '0;
      nacks_d = '0;
    end
  end

  fwb_run_counter #(
    .Limit     (F_MAX_STALL),
    .Inclusive (1'b0)
  ) u_stall_run (
    .clk   (i_clk),
    .rst_n (i_reset_n),
    .en    (stall_cond),
    .hit   (stall_hit)
  );

  fwb_run_counter #(
    .Limit     (F_MAX_ACK_DELAY),
    .Inclusive (1'b1)
  ) u_ack_run (
    .clk   (i_clk),
    .rst_n (i_reset_n),
    .en    (wait_cond),
    .hit   (ack_hit)
  );

  always_comb begin
    viol_now = '0;
    viol_now[VIOL_STB_NO_CYC]    = i_wb_stb & ~i_wb_cyc;
    // A stalled request must be presented unchanged until it is accepted.
    viol_now[VIOL_STALL_CHANGE]  = past_valid_q & past_stall_q & i_wb_cyc &
                                   (~i_wb_stb | (i_wb_we != past_we_q) |
                                    (i_wb_addr != past_addr_q) | (i_wb_sel != past_sel_q) |
                                    (past_we_q & (i_wb_data != past_data_q)));
    viol_now[VIOL_OVERFLOW]      = req & (nreqs_q == '1);
    viol_now[VIOL_CYC_AFTER_ERR] = past_valid_q & past_err_q & i_wb_cyc;
    viol_now[VIOL_ACK_AND_ERR]   = i_wb_ack & i_wb_err;
    viol_now[VIOL_ACK_NONE]      = resp & (f_outstanding == '0);
    viol_now[VIOL_STALL_TIMEOUT] = stall_hit;
    viol_now[VIOL_ACK_TIMEOUT]   = ack_hit;
    viol_d = viol_q | viol_now;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      nreqs_q      <= '0;
      nacks_q      <= '0;
      viol_q       <= '0;
      past_valid_q <= 1'b0;
      past_stall_q <= 1'b0;
      past_we_q    <= 1'b0;
      past_err_q   <= 1'b0;
      past_addr_q  <= '0;
      past_data_q  <= '0;
      past_sel_q   <= '0;
    end else begin
      nreqs_q      <= nreqs_d;
      nacks_q      <= nacks_d;
      viol_q       <= viol_d;
      past_valid_q <= 1'b1;
      past_stall_q <= stall_cond;
      past_we_q    <= i_wb_we;
      past_err_q   <= i_wb_cyc & i_wb_err;
      past_addr_q  <= i_wb_addr;
      past_data_q  <= i_wb_data;
      past_sel_q   <= i_wb_sel;
    end
  end

  assign f_nreqs       = nreqs_q;
  assign f_nacks       = nacks_q;
  assign f_outstanding = nreqs_q - nacks_q;
  assign o_viol        = viol_q;
  assign o_master_err  = |viol_q[3:0];
  assign o_slave_err   = |viol_q[7:4];

endmodule

// File: tb/tb_fwb_slave_checker.sv
// Directed bench for fwb_slave_checker: per-cycle expectations are queued as stimulus is
// driven and popped for comparison mid-cycle.
module tb_fwb_slave_checker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cyc, stb, we, ack, stall, err;
  logic [27:0] addr;
  logic [31:0] data, idata;
  logic [3:0]  sel;
  logic [3:0]  nreqs, nacks, outst;
  logic [7:0]  viol;
  logic        merr, serr;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string      tag;
    logic [3:0] nreqs;
    logic [3:0] nacks;
    logic [3:0] outst;
    logic [7:0] viol;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  fwb_slave_checker #(
    .AW              (28),
    .DW              (32),
    .F_MAX_STALL     (3),
    .F_MAX_ACK_DELAY (1),
    .F_LGDEPTH       (4)
  ) dut (
    .i_clk         (clk),
    .i_reset_n     (rst_n),
    .i_wb_cyc      (cyc),
    .i_wb_stb      (stb),
    .i_wb_we       (we),
    .i_wb_addr     (addr),
    .i_wb_data     (data),
    .i_wb_sel      (sel),
    .i_wb_ack      (ack),
    .i_wb_stall    (stall),
    .i_wb_idata    (idata),
    .i_wb_err      (err),
    .f_nreqs       (nreqs),
    .f_nacks       (nacks),
    .f_outstanding (outst),
    .o_viol        (viol),
    .o_master_err  (merr),
    .o_slave_err   (serr)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] en, input logic [3:0] ea,
                           input logic [3:0] eo, input logic [7:0] ev);
    check({tag, ".nreqs"}, {4'h0, nreqs}, {4'h0, en});
    check({tag, ".nacks"}, {4'h0, nacks}, {4'h0, ea});
    check({tag, ".outst"}, {4'h0, outst}, {4'h0, eo});
    check({tag, ".viol"}, viol, ev);
    check({tag, ".merr"}, {7'h0, merr}, {7'h0, |ev[3:0]});
    check({tag, ".serr"}, {7'h0, serr}, {7'h0, |ev[7:4]});
  endtask

  // mctl = {cyc, stb, we}, sctl = {ack, stall, err}; expectations are for what the
  // checker shows during this cycle, i.e. the result of all earlier cycles.
  task automatic step(input string tag, input logic [2:0] mctl, input logic [27:0] a,
                      input logic [2:0] sctl, input logic [3:0] en, input logic [3:0] ea,
                      input logic [3:0] eo, input logic [7:0] ev);
    exp_t e;
    {cyc, stb, we}    = mctl;
    {ack, stall, err} = sctl;
    addr  = a;
    data  = {4'h0, a} ^ 32'hA5A5_0000;
    sel   = 4'hF;
    idata = 32'h1234_5678;
    sb.push_back('{tag, en, ea, eo, ev});
    @(negedge clk);
    e = sb.pop_front();
    check_all(e.tag, e.nreqs, e.nacks, e.outst, e.viol);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    {cyc, stb, we}    = 3'b000;
    {ack, stall, err} = 3'b000;
    addr  = '0;
    data  = '0;
    sel   = '0;
    idata = '0;
  endtask

  // Asserted away from any clock edge; outputs must clear without waiting for a clock.
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    check_all(tag, 4'd0, 4'd0, 4'd0, 8'h00);
    idle_inputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    do_reset("rst.init");

    // Single write
    step("wr.c1", 3'b111, 28'h100, 3'b000, 4'd0, 4'd0, 4'd0, 8'h00);
    step("wr.c2", 3'b100, 28'h100, 3'b100, 4'd1, 4'd0, 4'd1, 8'h00);
    step("wr.c3", 3'b000, 28'h0,   3'b000, 4'd1, 4'd1, 4'd0, 8'h00);
    step("wr.c4", 3'b000, 28'h0,   3'b000, 4'd0, 4'd0, 4'd0, 8'h00);

    // Pipelined reads, each acked one cycle after acceptance
    step("rd.c1", 3'b110, 28'h0, 3'b000, 4'd0, 4'd0, 4'd0, 8'h00);
    step("rd.c2", 3'b110, 28'h4, 3'b100, 4'd1, 4'd0, 4'd1, 8'h00);
    step("rd.c3", 3'b110, 28'h8, 3'b100, 4'd2, 4'd1, 4'd1, 8'h00);
    step("rd.c4", 3'b100, 28'h0, 3'b100, 4'd3, 4'd2, 4'd1, 8'h00);
    step("rd.c5", 3'b000, 28'h0, 3'b000, 4'd3, 4'd3, 4'd0, 8'h00);
    step("rd.c6", 3'b000, 28'h0, 3'b000, 4'd0, 4'd0, 4'd0, 8'h00);

    // Address changes while stalled
    step("stc.c1", 3'b110, 28'h10, 3'b010, 4'd0, 4'd0, 4'd0, 8'h00);
    step("stc.c2", 3'b110, 28'h14, 3'b010, 4'd0, 4'd0, 4'd0, 8'h00);
    step("stc.c3", 3'b000, 28'h0,  3'b000, 4'd0, 4'd0, 4'd0, 8'h02);
    step("stc.c4", 3'b000, 28'h0,  3'b000, 4'd0, 4'd0, 4'd0, 8'h02);
    do_reset("rst.stc");

    // Ack with nothing outstanding
    step("ack0.c1", 3'b100, 28'h0, 3'b100, 4'd0, 4'd0, 4'd0,  8'h00);
    step("ack0.c2", 3'b000, 28'h0, 3'b000, 4'd0, 4'd1, 4'hF,  8'h20);
    step("ack0.c3", 3'b000, 28'h0, 3'b000, 4'd0, 4'd0, 4'd0,  8'h20);
    do_reset("rst.ack0");

    // Three stalls are tolerated, the fourth exceeds the limit
    for (int i = 0; i < 4; i++) begin
      step("stall.run", 3'b110, 28'h20, 3'b010, 4'd0, 4'd0, 4'd0, 8'h00);
    end
    step("stall.c5", 3'b000, 28'h0, 3'b000, 4'd0, 4'd0, 4'd0, 8'h40);
    do_reset("rst.stall");

    // One waiting cycle reaches the ack-delay limit
    step("wait.c1", 3'b110, 28'h30, 3'b000, 4'd0, 4'd0, 4'd0, 8'h00);
    step("wait.c2", 3'b100, 28'h0,  3'b000, 4'd1, 4'd0, 4'd1, 8'h00);
    step("wait.c3", 3'b100, 28'h0,  3'b100, 4'd1, 4'd0, 4'd1, 8'h80);
    step("wait.c4", 3'b000, 28'h0,  3'b000, 4'd1, 4'd1, 4'd0, 8'h80);
    do_reset("rst.wait");

    // stb without cyc
    step("stb.c1", 3'b010, 28'h0, 3'b000, 4'd0, 4'd0, 4'd0, 8'h00);
    step("stb.c2", 3'b000, 28'h0, 3'b000, 4'd0, 4'd0, 4'd0, 8'h01);
    do_reset("rst.stb");

    // ack and err together, then cyc held after err
    step("err.c1", 3'b110, 28'h40, 3'b000, 4'd0, 4'd0, 4'd0, 8'h00);
    step("err.c2", 3'b100, 28'h0,  3'b101, 4'd1, 4'd0, 4'd1, 8'h00);
    step("err.c3", 3'b100, 28'h0,  3'b000, 4'd0, 4'd0, 4'd0, 8'h10);
    step("err.c4", 3'b000, 28'h0,  3'b000, 4'd0, 4'd0, 4'd0, 8'h18);
    do_reset("rst.err");

    // Sixteen requests overflow a 4-bit request counter
    for (int i = 0; i < 16; i++) begin
      step("ovf.run", 3'b110, 28'(i), (i == 0) ? 3'b000 : 3'b100, 4'(i),
           (i == 0) ? 4'd0 : 4'(i - 1), (i == 0) ? 4'd0 : 4'd1, 8'h00);
    end
    step("ovf.end",  3'b100, 28'h0, 3'b100, 4'd0, 4'd15, 4'd1, 8'h04);
    step("ovf.idle", 3'b000, 28'h0, 3'b000, 4'd0, 4'd0,  4'd0, 8'h04);
    do_reset("rst.ovf");

    // Asynchronous reset with two requests in flight
    step("mid.c1", 3'b110, 28'h50, 3'b000, 4'd0, 4'd0, 4'd0, 8'h00);
    step("mid.c2", 3'b110, 28'h54, 3'b100, 4'd1, 4'd0, 4'd1, 8'h00);
    step("mid.c3", 3'b100, 28'h0,  3'b100, 4'd2, 4'd1, 4'd1, 8'h00);
    check("mid.pre", {4'h0, nreqs}, 8'h02);
    do_reset("rst.mid");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
